arp_rx_parser: RTL and testbench



---
 rtl/arp_rx_parser_pkg.sv | 80 ++++++++
 rtl/arp_rx_parser.sv | 145 ++++++++++++++
 tb/tb_arp_rx_parser.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/arp_rx_parser_pkg.sv
// ---------------------------------------------------------------------------
// arp_rx_parser_pkg
// Constants shared between the ARP receive parser and the ARP transmitter:
// protocol field values, byte offsets within an Ethernet+ARP header, parser
// state encodings, and small per-byte field helpers used by the parser.
// ---------------------------------------------------------------------------
package arp_rx_parser_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] HTYPE_ETH      = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4     = 16'h0800;
  localparam logic [7:0]  HLEN           = 8'd6;
  localparam logic [7:0]  PLEN           = 8'd4;
  localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
  localparam int          ARP_HDR_LEN    = 42;

  // Byte offsets from the first destination-MAC byte
  localparam logic [5:0] OFF_DST   = 6'd0;
  localparam logic [5:0] OFF_SRC   = 6'd6;
  localparam logic [5:0] OFF_ETYPE = 6'd12;
  localparam logic [5:0] OFF_HTYPE = 6'd14;
  localparam logic [5:0] OFF_PTYPE = 6'd16;
  localparam logic [5:0] OFF_HLEN  = 6'd18;
  localparam logic [5:0] OFF_PLEN  = 6'd19;
  localparam logic [5:0] OFF_OPER  = 6'd20;
  localparam logic [5:0] OFF_SHA   = 6'd22;
  localparam logic [5:0] OFF_SPA   = 6'd28;
  localparam logic [5:0] OFF_THA   = 6'd32;
  localparam logic [5:0] OFF_TPA   = 6'd38;
  localparam logic [5:0] OFF_LAST  = 6'(ARP_HDR_LEN - 1);
  localparam logic [5:0] CNT_MAX   = 6'd63;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PARSE = 2'd2,
    ST_DRAIN = 2'd3
  } arp_rx_state_t;

  // Byte n (0 = most significant) of a 48-bit MAC address
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] idx);
    logic [7:0] b;
    case (idx)
      6'd0:    b = mac[47:40];
      6'd1:    b = mac[39:32];
      6'd2:    b = mac[31:24];
      6'd3:    b = mac[23:16];
      6'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

  // Check of one header byte at offsets 6..41; offsets without a fixed value
  // (source MAC, sender fields, target MAC) always pass.
  function automatic logic field_ok(input logic [5:0] idx, input logic [7:0] b,
                                    input logic [31:0] ip);
    logic ok;
    case (idx)
      OFF_ETYPE:         ok = (b == ETHERTYPE_ARP[15:8]);
      OFF_ETYPE + 6'd1:  ok = (b == ETHERTYPE_ARP[7:0]);
      OFF_HTYPE:         ok = (b == HTYPE_ETH[15:8]);
      OFF_HTYPE + 6'd1:  ok = (b == HTYPE_ETH[7:0]);
      OFF_PTYPE:         ok = (b == PTYPE_IPV4[15:8]);
      OFF_PTYPE + 6'd1:  ok = (b == PTYPE_IPV4[7:0]);
      OFF_HLEN:          ok = (b == HLEN);
      OFF_PLEN:          ok = (b == PLEN);
      OFF_OPER:          ok = (b == ARP_OP_REQUEST[15:8]);
      OFF_OPER + 6'd1:   ok = (b == ARP_OP_REQUEST[7:0]);
      OFF_TPA:           ok = (b == ip[31:24]);
      OFF_TPA + 6'd1:    ok = (b == ip[23:16]);
      OFF_TPA + 6'd2:    ok = (b == ip[15:8]);
      OFF_TPA + 6'd3:    ok = (b == ip[7:0]);
      default:           ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/arp_rx_parser.sv
// ---------------------------------------------------------------------------
// arp_rx_parser
// Byte-serial receive parser for Ethernet/ARP. Recognises ARP requests that
// are broadcast or addressed to my_mac and target my_ip, then asks the ARP
// transmitter for a reply (send_mac) and presents the requester's MAC/IP.
//
// Ports
//   clk        in   rising-edge clock
//   areset     in   synchronous active-high reset
//   data_valid in   frame byte qualifier (low >= 1 cycle between frames)
//   data_rx    in   [7:0] frame byte, first byte is destination MAC
//   my_mac     in   [47:0] local MAC
//   my_ip      in   [31:0] local IPv4 address
//   tx_busy    in   ARP transmitter busy
//   send_mac   out  1-cycle reply request, one cycle after byte 41
//   source_mac out  [47:0] sender MAC of last accepted request
//   source_ip  out  [31:0] sender IP of last accepted request
//   frame_err  out  1-cycle pulse on a frame truncated while still matching
//   rx_drop    out  1-cycle pulse when a good request meets tx_busy
// ---------------------------------------------------------------------------
module arp_rx_parser
  import arp_rx_parser_pkg::*;
(
  input  logic        clk,
  input  logic        areset,
  input  logic        data_valid,
  input  logic [7:0]  data_rx,
  input  logic [47:0] my_mac,
  input  logic [31:0] my_ip,
  input  logic        tx_busy,
  output logic        send_mac,
  output logic [47:0] source_mac,
  output logic [31:0] source_ip,
  output logic        frame_err,
  output logic        rx_drop
);

  arp_rx_state_t r_state, w_state_nxt;
  logic [5:0]    r_cnt, w_cnt_nxt;
  // Destination may be broadcast or unicast; track both candidates so a
  // frame is only rejected once neither can still match.
  logic          r_bc_ok, w_bc_nxt;
  logic          r_uc_ok, w_uc_nxt;
  logic          w_byte_ok;
  logic          w_send, w_drop, w_ferr;
  logic [47:0]   r_sh_mac;
  logic [31:0]   r_sh_ip;
  logic          r_send_mac, r_frame_err, r_rx_drop;
  logic [47:0]   r_source_mac;
  logic [31:0]   r_source_ip;
  logic          w_cap_mac, w_cap_ip;

  assign send_mac   = r_send_mac;
  assign frame_err  = r_frame_err;
  assign rx_drop    = r_rx_drop;
  assign source_mac = r_source_mac;
  assign source_ip  = r_source_ip;

  assign w_cap_mac = (r_state == ST_PARSE) && data_valid &&
                     (r_cnt >= OFF_SHA) && (r_cnt < OFF_SPA);
  assign w_cap_ip  = (r_state == ST_PARSE) && data_valid &&
                     (r_cnt >= OFF_SPA) && (r_cnt < OFF_THA);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bc_nxt    = r_bc_ok;
    w_uc_nxt    = r_uc_ok;
    w_byte_ok   = 1'b1;
    w_send      = 1'b0;
    w_drop      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (!data_valid) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (data_valid) begin
          w_cnt_nxt = 6'd1;
          w_bc_nxt  = (data_rx == 8'hFF);
          w_uc_nxt  = (data_rx == mac_byte(my_mac, OFF_DST));
          w_state_nxt = (w_bc_nxt || w_uc_nxt) ? ST_PARSE : ST_DRAIN;
        end
      end
      ST_PARSE: begin
        if (!data_valid) begin
          w_ferr      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          if (r_cnt < OFF_SRC) begin
            w_bc_nxt  = r_bc_ok && (data_rx == 8'hFF);
            w_uc_nxt  = r_uc_ok && (data_rx == mac_byte(my_mac, r_cnt));
            w_byte_ok = w_bc_nxt || w_uc_nxt;
          end else begin
            w_byte_ok = field_ok(r_cnt, data_rx, my_ip);
          end
          if (!w_byte_ok) begin
            w_state_nxt = ST_DRAIN;
          end else if (r_cnt == OFF_LAST) begin
            w_state_nxt = ST_DRAIN;
            w_send      = !tx_busy;
            w_drop      = tx_busy;
          end else begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 6'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (!data_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state      <= ST_SYNC;
      r_cnt        <= 6'd0;
      r_bc_ok      <= 1'b0;
      r_uc_ok      <= 1'b0;
      r_send_mac   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rx_drop    <= 1'b0;
      r_source_mac <= 48'd0;
      r_source_ip  <= 32'd0;
      r_sh_mac     <= 48'd0;
      r_sh_ip      <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bc_ok     <= w_bc_nxt;
      r_uc_ok     <= w_uc_nxt;
      r_send_mac  <= w_send;
      r_frame_err <= w_ferr;
      r_rx_drop   <= w_drop;
      if (w_cap_mac) r_sh_mac <= {r_sh_mac[39:0], data_rx};
      if (w_cap_ip)  r_sh_ip  <= {r_sh_ip[23:0], data_rx};
      if (w_send) begin
        r_source_mac <= r_sh_mac;
        r_source_ip  <= r_sh_ip;
      end
    end
  end

endmodule

// File: tb/tb_arp_rx_parser.sv
// ---------------------------------------------------------------------------
// tb_arp_rx_parser
// Directed frames drive the parser; each expected pulse (kind, cycle, and for
// replies the requester MAC/IP) is queued by the driver and checked by an
// independent monitor, which also tracks the expected source_mac/source_ip.
// ---------------------------------------------------------------------------
module tb_arp_rx_parser;

  localparam int K_SEND = 1;
  localparam int K_DROP = 2;
  localparam int K_FERR = 3;
  localparam int K_NONE = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [47:0] mac;
    logic [31:0] ip;
  } exp_t;

  bit          clk = 1'b0;
  logic        areset;
  logic        data_valid;
  logic [7:0]  data_rx;
  logic [47:0] my_mac;
  logic [31:0] my_ip;
  logic        tx_busy;
  logic        send_mac;
  logic [47:0] source_mac;
  logic [31:0] source_ip;
  logic        frame_err;
  logic        rx_drop;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        rst_q = 1'b1;
  exp_t        q[$];
  logic [47:0] m_mac = 48'd0;
  logic [31:0] m_ip  = 32'd0;
  logic [7:0]  fr [60];

  localparam logic [47:0] MY_MAC = 48'h020000000001;
  localparam logic [31:0] MY_IP  = 32'hC0A8010A;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;

  arp_rx_parser dut (
    .clk(clk), .areset(areset), .data_valid(data_valid), .data_rx(data_rx),
    .my_mac(my_mac), .my_ip(my_ip), .tx_busy(tx_busy), .send_mac(send_mac),
    .source_mac(source_mac), .source_ip(source_ip), .frame_err(frame_err),
    .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= areset;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    int   act;
    exp_t e;
    if (rst_q) begin
      m_mac = 48'd0;
      m_ip  = 32'd0;
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL missing_pulse kind=%0d expected at cycle %0d, got none", e.kind, e.cyc);
    end
    act = K_NONE;
    if (send_mac) act = K_SEND;
    else if (rx_drop) act = K_DROP;
    else if (frame_err) act = K_FERR;
    if (act != K_NONE) begin
      checks++;
      if ((32'(send_mac) + 32'(rx_drop) + 32'(frame_err)) > 1) begin
        errors++;
        $display("FAIL pulse_overlap send=%b drop=%b ferr=%b, required one at a time",
                 send_mac, rx_drop, frame_err);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse kind=%0d at cycle %0d, required none", act, cyc);
      end else begin
        e = q.pop_front();
        if (e.kind != act || e.cyc != cyc) begin
          errors++;
          $display("FAIL pulse kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                   act, cyc, e.kind, e.cyc);
        end
        if (act == K_SEND && e.kind == K_SEND) begin
          m_mac = e.mac;
          m_ip  = e.ip;
        end
      end
    end
    checks++;
    if (source_mac !== m_mac || source_ip !== m_ip) begin
      errors++;
      $display("FAIL source_regs cycle %0d got %h/%h, required %h/%h",
               cyc, source_mac, source_ip, m_mac, m_ip);
    end
  end

  task automatic build(input logic [47:0] dst, input logic [15:0] et,
                       input logic [47:0] smac, input logic [31:0] sip,
                       input logic [31:0] tip);
    logic [47:0] srcm;
    srcm = 48'h029988776655;
    for (int i = 0; i < 60; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fr[i]      = 8'(dst  >> (40 - 8 * i));
      fr[6 + i]  = 8'(srcm >> (40 - 8 * i));
      fr[22 + i] = 8'(smac >> (40 - 8 * i));
      fr[32 + i] = 8'hEE;
    end
    fr[12] = et[15:8];  fr[13] = et[7:0];
    fr[14] = 8'h00;     fr[15] = 8'h01;
    fr[16] = 8'h08;     fr[17] = 8'h00;
    fr[18] = 8'h06;     fr[19] = 8'h04;
    fr[20] = 8'h00;     fr[21] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      fr[28 + i] = 8'(sip >> (24 - 8 * i));
      fr[38 + i] = 8'(tip >> (24 - 8 * i));
    end
  endtask

  // Drive len bytes of fr; kind says which pulse the frame must produce.
  // rst_at >= 0 pulses areset together with that byte.
  task automatic drive(input int len, input logic busy, input int kind,
                       input logic [47:0] emac, input logic [31:0] eip,
                       input int gap, input int rst_at);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_rx    = fr[i];
      tx_busy    = (i == 41) ? busy : 1'b0;
      areset     = (i == rst_at);
      if (i == 41 && (kind == K_SEND || kind == K_DROP)) begin
        e = '{kind: kind, cyc: cyc + 1, mac: emac, ip: eip};
        q.push_back(e);
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    data_rx    = 8'h00;
    tx_busy    = 1'b0;
    areset     = 1'b0;
    if (kind == K_FERR) begin
      e = '{kind: K_FERR, cyc: cyc + 1, mac: 48'd0, ip: 32'd0};
      q.push_back(e);
    end
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    areset     = 1'b1;
    data_valid = 1'b0;
    data_rx    = 8'h00;
    tx_busy    = 1'b0;
    my_mac     = MY_MAC;
    my_ip      = MY_IP;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    repeat (2) @(negedge clk);

    // Broadcast request for my_ip
    build(BCAST, 16'h0806, 48'h001122334455, 32'hC0A80105, 32'hC0A8010A);
    drive(60, 1'b0, K_SEND, 48'h001122334455, 32'hC0A80105, 3, -1);

    // Wrong target IP
    build(BCAST, 16'h0806, 48'h00AABBCCDDEE, 32'hC0A80107, 32'hC0A8010B);
    drive(60, 1'b0, K_NONE, 48'd0, 32'd0, 3, -1);

    // IPv4 ethertype, 1-cycle gap, then the valid request
    build(BCAST, 16'h0800, 48'h00AABBCCDDEE, 32'hC0A80107, 32'hC0A8010A);
    drive(60, 1'b0, K_NONE, 48'd0, 32'd0, 1, -1);
    build(BCAST, 16'h0806, 48'h001122334455, 32'hC0A80105, 32'hC0A8010A);
    drive(60, 1'b0, K_SEND, 48'h001122334455, 32'hC0A80105, 3, -1);

    // Truncated after byte 30
    build(BCAST, 16'h0806, 48'h00AABBCCDDEE, 32'hC0A80107, 32'hC0A8010A);
    drive(31, 1'b0, K_FERR, 48'd0, 32'd0, 3, -1);

    // Transmitter busy at byte 41
    drive(60, 1'b1, K_DROP, 48'd0, 32'd0, 3, -1);

    // Unicast to my_mac, new requester
    build(MY_MAC, 16'h0806, 48'h0066778899AA, 32'hC0A80120, 32'hC0A8010A);
    drive(60, 1'b0, K_SEND, 48'h0066778899AA, 32'hC0A80120, 3, -1);

    // Mixed broadcast/unicast destination is rejected
    build({8'hFF, MY_MAC[39:0]}, 16'h0806, 48'h00AABBCCDDEE, 32'hC0A80107, 32'hC0A8010A);
    drive(60, 1'b0, K_NONE, 48'd0, 32'd0, 3, -1);

    // Short frame that already failed a check: silent
    build(BCAST, 16'h0800, 48'h00AABBCCDDEE, 32'hC0A80107, 32'hC0A8010A);
    drive(20, 1'b0, K_NONE, 48'd0, 32'd0, 3, -1);

    // Reset at byte 20 with data_valid held: rest ignored, next frame replies
    build(BCAST, 16'h0806, 48'h00AABBCCDDEE, 32'hC0A80107, 32'hC0A8010A);
    drive(60, 1'b0, K_NONE, 48'd0, 32'd0, 2, 20);
    build(BCAST, 16'h0806, 48'h001122334455, 32'hC0A80105, 32'hC0A8010A);
    drive(60, 1'b0, K_SEND, 48'h001122334455, 32'hC0A80105, 5, -1);

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_expectations got %0d, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
